softmax_shift_sequencer: RTL

- Sequences one shared scalar shift unit across a packed vector of softmax intermediates, one element per cycle.
- Used for power-of-two scaling: exponent normalisation and reciprocal scaling.
- Sits between the max-subtract stage (upstream, valid/ready) and the exp/accumulate stage (downstream, valid/ready).
- Holds one vector at a time and presents the full shifted vector as a single output beat.

---
 rtl/softmax_shift_pkg.sv | 21 ++
 rtl/softmax_shift_lane.sv | 53 +++++
 rtl/softmax_shift_sequencer.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/softmax_shift_pkg.sv
// Shared types and constants for the softmax shift sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package softmax_shift_pkg;

  localparam int DATA_W_DEF  = 8;
  localparam int VEC_LEN_DEF = 4;
  localparam int SHIFT_W_DEF = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Bit offset of element idx inside a packed vector of data_w-wide elements.
  function automatic int elem_lsb(input int idx, input int data_w);
    return idx * data_w;
  endfunction

endpackage

// File: rtl/softmax_shift_lane.sv
// Single-element power-of-two shifter: arithmetic right, logical left; optional
// left-overflow saturation when SOFTMAX_SHIFT_SAT_EN is defined.
// Latency: purely combinational. Backpressure: none (no state).
module softmax_shift_lane
  import softmax_shift_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int SHIFT_W = SHIFT_W_DEF
) (
  input  logic [DATA_W-1:0]  din,
  input  logic [SHIFT_W-1:0] shamt,
  input  logic               dir,
`ifdef SOFTMAX_SHIFT_SAT_EN
  output logic               ovf,
`endif
  output logic [DATA_W-1:0]  dout
);

  logic [DATA_W-1:0] right_v;

`ifdef SOFTMAX_SHIFT_SAT_EN
  // Wide enough to hold the exact product din * 2^shamt for any shamt.
  localparam int EXT_W = DATA_W + (1 << SHIFT_W);

  logic [EXT_W-1:0] ext;
  logic [EXT_W-1:0] ext_sh;
  logic             fits;

  // Exact left product, representability test and saturation select.
  always_comb begin
    ext     = {{(EXT_W-DATA_W){din[DATA_W-1]}}, din};
    ext_sh  = ext << shamt;
    // Representable iff everything from the result sign bit upward is one copy of the sign.
    fits    = (&ext_sh[EXT_W-1:DATA_W-1]) | ~(|ext_sh[EXT_W-1:DATA_W-1]);
    right_v = DATA_W'($signed(din) >>> shamt);
    ovf     = ~dir & ~fits;
    if (dir) begin
      dout = right_v;
    end else if (!fits) begin
      dout = din[DATA_W-1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
    end else begin
      dout = ext_sh[DATA_W-1:0];
    end
  end
`else
  // Plain shift; left overflow simply drops the high bits.
  always_comb begin
    right_v = DATA_W'($signed(din) >>> shamt);
    dout    = dir ? right_v : (din << shamt);
  end
`endif

endmodule

// File: rtl/softmax_shift_sequencer.sv
// Walks one shared shift lane across a captured vector, one element per cycle (SOFTMAX_SHIFT_SAT_EN adds saturation + out_sat).
// Latency: out_valid high VEC_LEN edges after acceptance; one vector per VEC_LEN+2 cycles.
// Backpressure: single vector in flight; in_ready only in IDLE, result held in DONE until out_ready.
module softmax_shift_sequencer
  import softmax_shift_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int VEC_LEN = VEC_LEN_DEF,
  parameter int SHIFT_W = SHIFT_W_DEF
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [VEC_LEN*DATA_W-1:0] in_data,
  input  logic [SHIFT_W-1:0]        in_shamt,
  input  logic                      in_dir,
  output logic                      out_valid,
  input  logic                      out_ready,
`ifdef SOFTMAX_SHIFT_SAT_EN
  output logic                      out_sat,
`endif
  output logic [VEC_LEN*DATA_W-1:0] out_data,
  output logic                      busy
);

  localparam int IDX_W = $clog2(VEC_LEN);

  state_t                    state;
  state_t                    state_nxt;
  logic [IDX_W-1:0]          idx;
  logic [VEC_LEN*DATA_W-1:0] src;
  logic [VEC_LEN*DATA_W-1:0] dst;
  logic [SHIFT_W-1:0]        shamt_q;
  logic                      dir_q;
  logic                      out_valid_q;
  logic                      accept;
  logic                      last;
  logic [DATA_W-1:0]         lane_din;
  logic [DATA_W-1:0]         lane_dout;
`ifdef SOFTMAX_SHIFT_SAT_EN
  logic                      lane_ovf;
  logic                      sat_q;
`endif

  assign lane_din  = src[elem_lsb(int'(idx), DATA_W) +: DATA_W];
  assign out_data  = dst;
  assign out_valid = out_valid_q;
  assign busy      = (state != IDLE);
`ifdef SOFTMAX_SHIFT_SAT_EN
  assign out_sat   = sat_q;
`endif

  softmax_shift_lane #(
    .DATA_W  (DATA_W),
    .SHIFT_W (SHIFT_W)
  ) u_lane (
    .din   (lane_din),
    .shamt (shamt_q),
    .dir   (dir_q),
`ifdef SOFTMAX_SHIFT_SAT_EN
    .ovf   (lane_ovf),
`endif
    .dout  (lane_dout)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and handshake decode; flush overrides every transition.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    accept    = 1'b0;
    last      = (idx == IDX_W'(VEC_LEN-1));
    case (state)
      IDLE: begin
        in_ready = ~flush;
        if (in_valid && !flush) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (last) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (flush) begin
      state_nxt = IDLE;
    end
  end

  // Capture, per-element write-back and output valid; flush leaves src/dst stale.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx         <= '0;
      src         <= '0;
      dst         <= '0;
      shamt_q     <= '0;
      dir_q       <= 1'b0;
      out_valid_q <= 1'b0;
`ifdef SOFTMAX_SHIFT_SAT_EN
      sat_q       <= 1'b0;
`endif
    end else if (flush) begin
      idx         <= '0;
      out_valid_q <= 1'b0;
`ifdef SOFTMAX_SHIFT_SAT_EN
      sat_q       <= 1'b0;
`endif
    end else begin
      if (accept) begin
        src     <= in_data;
        shamt_q <= in_shamt;
        dir_q   <= in_dir;
        idx     <= '0;
`ifdef SOFTMAX_SHIFT_SAT_EN
        sat_q   <= 1'b0;
`endif
      end
      if (state == RUN) begin
        dst[elem_lsb(int'(idx), DATA_W) +: DATA_W] <= lane_dout;
`ifdef SOFTMAX_SHIFT_SAT_EN
        sat_q <= sat_q | lane_ovf;
`endif
        if (last) begin
          idx         <= '0;
          out_valid_q <= 1'b1;
        end else begin
          idx <= idx + IDX_W'(1);
        end
      end
      if (state == DONE && out_ready) begin
        out_valid_q <= 1'b0;
`ifdef SOFTMAX_SHIFT_SAT_EN
        sat_q       <= 1'b0;
`endif
      end
    end
  end

endmodule
